// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the hazard scoreboard: forward-source selects and
// producer latency classes.
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    FWD_RF     = 2'd0,
    FWD_EX_OUT = 2'd1,
    FWD_MEM    = 2'd2,
    FWD_WB     = 2'd3
  } fwd_sel_e;

  typedef enum logic [1:0] {
    LAT_ALU  = 2'd1,
    LAT_LOAD = 2'd2
  } lat_class_e;

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One scoreboard slot: tracks whether a register has an in-flight producer,
// how far down the pipe it is, and the age at which its result is bypassable.
module scoreboard_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int AGE_W      = 2,
  parameter int PIPE_DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freeze,
  input  logic             issue,
  input  logic [AGE_W-1:0] lat,
  output logic             busy,
  output logic [AGE_W-1:0] age,
  output logic [AGE_W-1:0] rdy
);

  localparam logic [AGE_W-1:0] LAST_AGE = AGE_W'(PIPE_DEPTH - 1);

  // A fresh issue replaces whatever the slot held: the younger writer wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      age  <= '0;
      rdy  <= '0;
    end else if (!freeze) begin
      if (issue) begin
        busy <= 1'b1;
        age  <= '0;
        rdy  <= lat;
      end else if (busy && age == LAST_AGE) begin
        busy <= 1'b0;
        age  <= '0;
      end else if (busy) begin
        age <= age + AGE_W'(1);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register hazard scoreboard beside ID: decides stall/flush/bubble and the
// EX/ID bypass selects, and counts stall and flush cycles.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_W              = 2,
  parameter int PIPE_DEPTH         = 3,
  parameter int AGE_W              = 2,
  parameter int DATA_FORWARDING    = 1,
  parameter int RF_SELF_FORWARDING = 1,
  parameter int CNT_W              = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_use_rs_early,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_writes,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic [AGE_W-1:0] id_lat,
  input  logic             jump_miss,
  input  logic             branch_miss,
  input  logic             freeze,
  output logic             pc_write,
  output logic             ir_write,
  output logic             bubblify,
  output logic             flush_if,
  output logic             incr_num_inst,
  output logic [AGE_W-1:0] fwd_rs,
  output logic [AGE_W-1:0] fwd_rt,
  output logic [AGE_W-1:0] fwd_rs_early,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int NUM_REGS = 2 ** REG_W;
  localparam logic [AGE_W-1:0] LAST_AGE = AGE_W'(PIPE_DEPTH - 1);
  localparam bit FWD_EN   = (DATA_FORWARDING != 0);
  localparam bit SELF_FWD = (RF_SELF_FORWARDING != 0);

  logic                busy [NUM_REGS];
  logic [AGE_W-1:0]    age  [NUM_REGS];
  logic [AGE_W-1:0]    rdy  [NUM_REGS];
  logic [NUM_REGS-1:0] issue_vec;
  logic [AGE_W-1:0]    lat_eff;
  logic                issue;
  logic                data_stall;
  logic                hit_rs, hit_rt;
  logic                stall_rs, stall_rt, stall_early;
  logic [AGE_W:0]      age_rs_x, age_rt_x, rdy_rs_x, rdy_rt_x;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
    scoreboard_entry #(
      .AGE_W     (AGE_W),
      .PIPE_DEPTH(PIPE_DEPTH)
    ) u_entry (
      .clk   (clk),
      .reset (reset),
      .freeze(freeze),
      .issue (issue_vec[i]),
      .lat   (lat_eff),
      .busy  (busy[i]),
      .age   (age[i]),
      .rdy   (rdy[i])
    );
  end

  // With RF write-through, a producer sitting in WB is already visible to a read.
  function automatic logic hit_of(input logic b, input logic [AGE_W-1:0] a);
    return b && !(SELF_FWD && a == LAST_AGE);
  endfunction

  assign hit_rs   = hit_of(busy[id_rs], age[id_rs]);
  assign hit_rt   = hit_of(busy[id_rt], age[id_rt]);
  assign age_rs_x = {1'b0, age[id_rs]};
  assign age_rt_x = {1'b0, age[id_rt]};
  assign rdy_rs_x = {1'b0, rdy[id_rs]};
  assign rdy_rt_x = {1'b0, rdy[id_rt]};

  assign stall_rs    = id_use_rs && hit_rs &&
                       (!FWD_EN || (age_rs_x + (AGE_W+1)'(1)) < rdy_rs_x);
  assign stall_rt    = id_use_rt && hit_rt &&
                       (!FWD_EN || (age_rt_x + (AGE_W+1)'(1)) < rdy_rt_x);
  assign stall_early = id_use_rs_early && hit_rs &&
                       (!FWD_EN || age[id_rs] < rdy[id_rs]);
  assign data_stall  = id_valid && (stall_rs || stall_rt || stall_early);

  assign issue = id_valid && id_writes && !data_stall && !branch_miss && !freeze;

  always_comb begin
    issue_vec = '0;
    issue_vec[id_wr_reg] = issue;
  end

  always_comb begin
    lat_eff = id_lat;
    if (lat_eff == '0) lat_eff = AGE_W'(LAT_ALU);
    if (lat_eff > LAST_AGE) lat_eff = LAST_AGE;
  end

  always_comb begin
    pc_write     = 1'b1;
    ir_write     = 1'b1;
    bubblify     = 1'b0;
    flush_if     = 1'b0;
    fwd_rs       = AGE_W'(FWD_RF);
    fwd_rt       = AGE_W'(FWD_RF);
    fwd_rs_early = AGE_W'(FWD_RF);
    if (!reset) begin
      if (freeze) begin
        pc_write = 1'b0;
        ir_write = 1'b0;
      end else if (data_stall) begin
        pc_write = 1'b0;
        ir_write = 1'b0;
        bubblify = 1'b1;
      end else begin
        flush_if = jump_miss || branch_miss;
        bubblify = branch_miss;
      end
      // Age 0 (EX) lands in MEM by the time the consumer reaches EX.
      if (FWD_EN && !data_stall) begin
        if (hit_rs) fwd_rs       = age[id_rs] + AGE_W'(FWD_MEM);
        if (hit_rt) fwd_rt       = age[id_rt] + AGE_W'(FWD_MEM);
        if (hit_rs) fwd_rs_early = age[id_rs] + AGE_W'(FWD_EX_OUT);
      end
    end
  end

  assign incr_num_inst = !(bubblify || flush_if || freeze);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!freeze) begin
      if (data_stall) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_if)   flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus a randomized run against
// a model that tracks in-flight producers as a queue of pipeline occupants.
module tb_hazard_scoreboard;

  localparam int PD    = 3;
  localparam int AW    = 2;
  localparam int RW    = 2;
  localparam int CW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid, id_use_rs, id_use_rt, id_use_rs_early, id_writes;
  logic [RW-1:0] id_rs, id_rt, id_wr_reg;
  logic [AW-1:0] id_lat;
  logic          jump_miss, branch_miss, freeze;

  logic          pc_write, ir_write, bubblify, flush_if, incr_num_inst;
  logic [AW-1:0] fwd_rs, fwd_rt, fwd_rs_early;
  logic [CW-1:0] stall_cnt, flush_cnt;

  logic          nf_pc_write, nf_ir_write, nf_bubblify, nf_flush_if, nf_incr;
  logic [AW-1:0] nf_fwd_rs, nf_fwd_rt, nf_fwd_rs_early;
  logic [CW-1:0] nf_stall_cnt, nf_flush_cnt;

  int checks;
  int failures;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_use_rs_early(id_use_rs_early), .id_rs(id_rs),
    .id_rt(id_rt), .id_writes(id_writes), .id_wr_reg(id_wr_reg), .id_lat(id_lat),
    .jump_miss(jump_miss), .branch_miss(branch_miss), .freeze(freeze),
    .pc_write(pc_write), .ir_write(ir_write), .bubblify(bubblify),
    .flush_if(flush_if), .incr_num_inst(incr_num_inst), .fwd_rs(fwd_rs),
    .fwd_rt(fwd_rt), .fwd_rs_early(fwd_rs_early), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  hazard_scoreboard #(.DATA_FORWARDING(0)) dut_nf (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_use_rs_early(id_use_rs_early), .id_rs(id_rs),
    .id_rt(id_rt), .id_writes(id_writes), .id_wr_reg(id_wr_reg), .id_lat(id_lat),
    .jump_miss(jump_miss), .branch_miss(branch_miss), .freeze(freeze),
    .pc_write(nf_pc_write), .ir_write(nf_ir_write), .bubblify(nf_bubblify),
    .flush_if(nf_flush_if), .incr_num_inst(nf_incr), .fwd_rs(nf_fwd_rs),
    .fwd_rt(nf_fwd_rt), .fwd_rs_early(nf_fwd_rs_early), .stall_cnt(nf_stall_cnt),
    .flush_cnt(nf_flush_cnt)
  );

  // Reference model: ordered list of producers still in the pipe.
  typedef struct {
    int dst;
    int stage;
    int rdy;
  } prod_t;

  prod_t inflight[$];
  int    m_stall_cnt, m_flush_cnt;
  logic  e_pc, e_ir, e_bub, e_flush, e_incr, e_stall;
  int    e_fwd_rs, e_fwd_rt, e_fwd_early;

  function automatic bit visible(input int r, output int a, output int rd);
    a  = 0;
    rd = 0;
    for (int i = inflight.size() - 1; i >= 0; i--) begin
      if (inflight[i].dst == r) begin
        a  = inflight[i].stage;
        rd = inflight[i].rdy;
        return (a != PD - 1);
      end
    end
    return 1'b0;
  endfunction

  task automatic model_eval();
    bit vs, vt, s_rs, s_rt, s_early;
    int as_, rs_, at, rt_;
    vs = visible(int'(id_rs), as_, rs_);
    vt = visible(int'(id_rt), at, rt_);
    s_rs    = id_use_rs && vs && (as_ + 1 < rs_);
    s_rt    = id_use_rt && vt && (at + 1 < rt_);
    s_early = id_use_rs_early && vs && (as_ < rs_);
    e_stall = id_valid && (s_rs || s_rt || s_early);
    e_fwd_rs    = (vs && !e_stall) ? as_ + 2 : 0;
    e_fwd_rt    = (vt && !e_stall) ? at + 2 : 0;
    e_fwd_early = (vs && !e_stall) ? as_ + 1 : 0;
    e_pc = 1; e_ir = 1; e_bub = 0; e_flush = 0;
    if (freeze) begin
      e_pc = 0; e_ir = 0;
    end else if (e_stall) begin
      e_pc = 0; e_ir = 0; e_bub = 1;
    end else begin
      e_flush = jump_miss || branch_miss;
      e_bub   = branch_miss;
    end
    e_incr = !(e_bub || e_flush || freeze);
  endtask

  task automatic model_step();
    prod_t nq[$];
    prod_t p;
    int    l;
    if (freeze) return;
    if (e_stall) m_stall_cnt++;
    if (e_flush) m_flush_cnt++;
    foreach (inflight[i]) begin
      p = inflight[i];
      p.stage++;
      if (p.stage <= PD - 1) nq.push_back(p);
    end
    inflight = nq;
    if (id_valid && id_writes && !e_stall && !branch_miss) begin
      l = int'(id_lat);
      if (l == 0) l = 1;
      if (l > PD - 1) l = PD - 1;
      p.dst = int'(id_wr_reg);
      p.stage = 0;
      p.rdy = l;
      inflight.push_back(p);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_use_rs_early = 0;
    id_rs = '0; id_rt = '0; id_writes = 0; id_wr_reg = '0; id_lat = '0;
    jump_miss = 0; branch_miss = 0; freeze = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    @(negedge clk);
    reset = 0;
    inflight.delete();
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  task automatic write_op(input int r, input int lat);
    idle();
    id_valid = 1; id_writes = 1; id_wr_reg = RW'(r); id_lat = AW'(lat);
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    #1;
    checks++; if (pc_write !== 1'b1) begin failures++; $display("FAIL reset_pc_write got=%b exp=1", pc_write); end
    checks++; if (ir_write !== 1'b1) begin failures++; $display("FAIL reset_ir_write got=%b exp=1", ir_write); end
    checks++; if (bubblify !== 1'b0 || flush_if !== 1'b0) begin failures++; $display("FAIL reset_bub_flush got=%b%b exp=00", bubblify, flush_if); end
    checks++; if (fwd_rs !== 0 || fwd_rt !== 0 || fwd_rs_early !== 0) begin failures++; $display("FAIL reset_fwd got=%0d/%0d/%0d exp=0/0/0", fwd_rs, fwd_rt, fwd_rs_early); end
    checks++; if (stall_cnt !== 0 || flush_cnt !== 0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_alu_forward();
    do_reset();
    write_op(1, 1);
    tick();
    idle();
    id_valid = 1; id_use_rs = 1; id_rs = 2'd1;
    #1;
    checks++; if (pc_write !== 1'b1 || bubblify !== 1'b0) begin failures++; $display("FAIL alu_no_stall got pc=%b bub=%b exp pc=1 bub=0", pc_write, bubblify); end
    checks++; if (fwd_rs !== 2'd2) begin failures++; $display("FAIL alu_fwd_rs got=%0d exp=2", fwd_rs); end
    checks++; if (incr_num_inst !== 1'b1) begin failures++; $display("FAIL alu_incr got=%b exp=1", incr_num_inst); end
    tick();
  endtask

  task automatic test_load_stall();
    do_reset();
    write_op(2, 2);
    tick();
    idle();
    id_valid = 1; id_use_rt = 1; id_rt = 2'd2; id_writes = 1; id_wr_reg = 2'd0; id_lat = 2'd1;
    #1;
    checks++; if (pc_write !== 1'b0 || ir_write !== 1'b0 || bubblify !== 1'b1) begin failures++; $display("FAIL load_stall got pc=%b ir=%b bub=%b exp 0 0 1", pc_write, ir_write, bubblify); end
    tick();
    #1;
    checks++; if (pc_write !== 1'b1 || fwd_rt !== 2'd3) begin failures++; $display("FAIL load_after got pc=%b fwd_rt=%0d exp pc=1 fwd_rt=3", pc_write, fwd_rt); end
    checks++; if (stall_cnt !== 32'd1) begin failures++; $display("FAIL load_stall_cnt got=%0d exp=1", stall_cnt); end
    tick();
    idle();
    #1;
    checks++; if (stall_cnt !== 32'd1) begin failures++; $display("FAIL load_stall_cnt_hold got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_early();
    do_reset();
    write_op(3, 1);
    tick();
    idle();
    id_valid = 1; id_use_rs_early = 1; id_rs = 2'd3;
    #1;
    checks++; if (pc_write !== 1'b0 || bubblify !== 1'b1) begin failures++; $display("FAIL early_stall got pc=%b bub=%b exp 0 1", pc_write, bubblify); end
    checks++; if (nf_pc_write !== 1'b0) begin failures++; $display("FAIL nofwd_early_stall0 got=%b exp=0", nf_pc_write); end
    tick();
    #1;
    checks++; if (pc_write !== 1'b1 || fwd_rs_early !== 2'd2) begin failures++; $display("FAIL early_fwd got pc=%b fwd=%0d exp pc=1 fwd=2", pc_write, fwd_rs_early); end
    checks++; if (nf_pc_write !== 1'b0) begin failures++; $display("FAIL nofwd_early_stall1 got=%b exp=0", nf_pc_write); end
    tick();
    #1;
    checks++; if (nf_pc_write !== 1'b1 || nf_fwd_rs_early !== 2'd0) begin failures++; $display("FAIL nofwd_early_release got pc=%b fwd=%0d exp pc=1 fwd=0", nf_pc_write, nf_fwd_rs_early); end
    tick();
  endtask

  task automatic test_freeze();
    do_reset();
    write_op(2, 2);
    tick();
    idle();
    id_valid = 1; id_use_rt = 1; id_rt = 2'd2; freeze = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (pc_write !== 1'b0 || bubblify !== 1'b0 || flush_if !== 1'b0 || incr_num_inst !== 1'b0) begin failures++; $display("FAIL freeze_outputs cyc=%0d got pc=%b bub=%b fl=%b inc=%b exp 0 0 0 0", i, pc_write, bubblify, flush_if, incr_num_inst); end
      checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL freeze_stall_cnt cyc=%0d got=%0d exp=0", i, stall_cnt); end
      tick();
    end
    freeze = 0;
    #1;
    checks++; if (pc_write !== 1'b0 || bubblify !== 1'b1) begin failures++; $display("FAIL freeze_release_stall got pc=%b bub=%b exp 0 1", pc_write, bubblify); end
    tick();
    #1;
    checks++; if (pc_write !== 1'b1 || fwd_rt !== 2'd3 || stall_cnt !== 32'd1) begin failures++; $display("FAIL freeze_release_fwd got pc=%b fwd_rt=%0d cnt=%0d exp 1 3 1", pc_write, fwd_rt, stall_cnt); end
    tick();
  endtask

  task automatic test_branch_jump();
    do_reset();
    write_op(1, 1);
    branch_miss = 1;
    #1;
    checks++; if (flush_if !== 1'b1 || bubblify !== 1'b1 || pc_write !== 1'b1 || incr_num_inst !== 1'b0) begin failures++; $display("FAIL branch_outputs got fl=%b bub=%b pc=%b inc=%b exp 1 1 1 0", flush_if, bubblify, pc_write, incr_num_inst); end
    tick();
    idle();
    id_valid = 1; id_use_rs = 1; id_rs = 2'd1;
    #1;
    checks++; if (fwd_rs !== 2'd0 || pc_write !== 1'b1) begin failures++; $display("FAIL branch_no_issue got fwd=%0d pc=%b exp 0 1", fwd_rs, pc_write); end
    checks++; if (flush_cnt !== 32'd1) begin failures++; $display("FAIL branch_flush_cnt got=%0d exp=1", flush_cnt); end
    tick();
    write_op(2, 1);
    jump_miss = 1;
    #1;
    checks++; if (flush_if !== 1'b1 || bubblify !== 1'b0) begin failures++; $display("FAIL jump_outputs got fl=%b bub=%b exp 1 0", flush_if, bubblify); end
    tick();
    idle();
    id_valid = 1; id_use_rs = 1; id_rs = 2'd2;
    #1;
    checks++; if (fwd_rs !== 2'd2 || flush_cnt !== 32'd2) begin failures++; $display("FAIL jump_issue got fwd=%0d cnt=%0d exp 2 2", fwd_rs, flush_cnt); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    write_op(1, 2);
    tick();
    write_op(1, 1);
    tick();
    idle();
    id_valid = 1; id_use_rs = 1; id_rs = 2'd1;
    #1;
    checks++; if (pc_write !== 1'b1 || fwd_rs !== 2'd2) begin failures++; $display("FAIL waw_younger got pc=%b fwd=%0d exp 1 2", pc_write, fwd_rs); end
    reset = 1;
    #1;
    checks++; if (fwd_rs !== 2'd0 || pc_write !== 1'b1) begin failures++; $display("FAIL waw_in_reset got fwd=%0d pc=%b exp 0 1", fwd_rs, pc_write); end
    @(negedge clk);
    reset = 0;
    #1;
    checks++; if (fwd_rs !== 2'd0) begin failures++; $display("FAIL waw_after_reset got fwd=%0d exp=0", fwd_rs); end
    @(negedge clk);
    write_op(2, 2);
    tick();
    idle();
    id_valid = 1; id_use_rt = 1; id_rt = 2'd2;
    #1;
    checks++; if (pc_write !== 1'b0) begin failures++; $display("FAIL midstall_pre got pc=%b exp=0", pc_write); end
    reset = 1;
    #1;
    checks++; if (pc_write !== 1'b1 || bubblify !== 1'b0) begin failures++; $display("FAIL midstall_in_reset got pc=%b bub=%b exp 1 0", pc_write, bubblify); end
    @(negedge clk);
    reset = 0;
    #1;
    checks++; if (pc_write !== 1'b1 || bubblify !== 1'b0 || stall_cnt !== 32'd0) begin failures++; $display("FAIL midstall_after got pc=%b bub=%b cnt=%0d exp 1 0 0", pc_write, bubblify, stall_cnt); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      id_valid        = ($urandom_range(0, 9) < 8);
      id_use_rs       = $urandom_range(0, 1) == 1;
      id_use_rt       = $urandom_range(0, 1) == 1;
      id_use_rs_early = ($urandom_range(0, 9) < 2);
      id_rs           = RW'($urandom_range(0, 3));
      id_rt           = RW'($urandom_range(0, 3));
      id_writes       = ($urandom_range(0, 9) < 6);
      id_wr_reg       = RW'($urandom_range(0, 3));
      id_lat          = AW'($urandom_range(0, 3));
      jump_miss       = ($urandom_range(0, 9) == 0);
      branch_miss     = ($urandom_range(0, 9) == 0);
      freeze          = ($urandom_range(0, 9) == 0);
      #1;
      model_eval();
      checks++; if (pc_write !== e_pc) begin failures++; $display("FAIL rnd_pc_write n=%0d got=%b exp=%b", n, pc_write, e_pc); end
      checks++; if (ir_write !== e_ir) begin failures++; $display("FAIL rnd_ir_write n=%0d got=%b exp=%b", n, ir_write, e_ir); end
      checks++; if (bubblify !== e_bub) begin failures++; $display("FAIL rnd_bubblify n=%0d got=%b exp=%b", n, bubblify, e_bub); end
      checks++; if (flush_if !== e_flush) begin failures++; $display("FAIL rnd_flush_if n=%0d got=%b exp=%b", n, flush_if, e_flush); end
      checks++; if (incr_num_inst !== e_incr) begin failures++; $display("FAIL rnd_incr n=%0d got=%b exp=%b", n, incr_num_inst, e_incr); end
      checks++; if (fwd_rs !== AW'(e_fwd_rs)) begin failures++; $display("FAIL rnd_fwd_rs n=%0d got=%0d exp=%0d", n, fwd_rs, e_fwd_rs); end
      checks++; if (fwd_rt !== AW'(e_fwd_rt)) begin failures++; $display("FAIL rnd_fwd_rt n=%0d got=%0d exp=%0d", n, fwd_rt, e_fwd_rt); end
      checks++; if (fwd_rs_early !== AW'(e_fwd_early)) begin failures++; $display("FAIL rnd_fwd_early n=%0d got=%0d exp=%0d", n, fwd_rs_early, e_fwd_early); end
      checks++; if (stall_cnt !== CW'(m_stall_cnt)) begin failures++; $display("FAIL rnd_stall_cnt n=%0d got=%0d exp=%0d", n, stall_cnt, m_stall_cnt); end
      checks++; if (flush_cnt !== CW'(m_flush_cnt)) begin failures++; $display("FAIL rnd_flush_cnt n=%0d got=%0d exp=%0d", n, flush_cnt, m_flush_cnt); end
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
    idle();
    test_reset();
    test_alu_forward();
    test_load_stall();
    test_early();
    test_freeze();
    test_branch_jump();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
